// File: rtl/stage_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : stage_sequencer
// Description : Single-clock stage sequencer for an N-stage multicycle core.
//               Produces a one-hot registered enable for the active stage in
//               place of derived phase clocks. It supports per-stage busy
//               stalls, flush-to-fetch, halt at the instruction boundary, a
//               stall watchdog and a retired-instruction counter.
//
// Ports       : i_clk        core clock, rising edge
//               i_reset      asynchronous reset, active-high
//               i_run        level, allows sequencing out of IDLE/HALTED
//               i_halt       level, stop at the next instruction boundary
//               i_flush      pulse, abandon instruction and restart at stage 0
//               i_stage_busy per-stage busy, bit k holds stage k
//               o_stage_en   one-hot enable of the active stage (0 if not RUN)
//               o_stage_idx  index of the active stage
//               o_instr_done one-cycle pulse after the last stage completes
//               o_retired    completed-instruction count (wraps)
//               o_timeout    sticky watchdog flag
//               o_state      IDLE=0, RUN=1, HALTED=2
//
// Revision    : 1.0 - initial release
// ============================================================================
module stage_sequencer #(
    parameter int NUM_STAGES = 5,
    parameter int CNT_W      = 32,
    parameter int TIMEOUT    = 255,
    parameter int TO_W       = 8
) (
    input  logic                          i_clk,
    input  logic                          i_reset,
    input  logic                          i_run,
    input  logic                          i_halt,
    input  logic                          i_flush,
    input  logic [NUM_STAGES-1:0]         i_stage_busy,
    output logic [NUM_STAGES-1:0]         o_stage_en,
    output logic [$clog2(NUM_STAGES)-1:0] o_stage_idx,
    output logic                          o_instr_done,
    output logic [CNT_W-1:0]              o_retired,
    output logic                          o_timeout,
    output logic [1:0]                    o_state
);

    localparam int IDX_W = $clog2(NUM_STAGES);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_RUN    = 2'd1;
    localparam logic [1:0] S_HALTED = 2'd2;

    localparam logic [IDX_W-1:0]      c_last_idx = IDX_W'(NUM_STAGES - 1);
    localparam logic [TO_W-1:0]       c_timeout  = TO_W'(TIMEOUT);
    localparam logic [NUM_STAGES-1:0] c_en_first = NUM_STAGES'(1);

    logic [1:0]            r_state;
    logic [IDX_W-1:0]      r_idx;
    logic [NUM_STAGES-1:0] r_en;
    logic                  r_done;
    logic [CNT_W-1:0]      r_retired;
    logic                  r_timeout;
    logic [TO_W-1:0]       r_wd;

    logic w_busy;
    logic w_force;
    logic w_hold;
    logic w_last;

    assign w_busy  = i_stage_busy[r_idx];
    // Once the stall count has reached the limit the stage is pushed on as if
    // it were idle; a zero limit turns the watchdog off entirely.
    assign w_force = (TIMEOUT != 0) && (r_wd == c_timeout);
    assign w_hold  = w_busy && !w_force;
    assign w_last  = (r_idx == c_last_idx);

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state   <= S_IDLE;
            r_idx     <= '0;
            r_en      <= '0;
            r_done    <= 1'b0;
            r_retired <= '0;
            r_timeout <= 1'b0;
            r_wd      <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (i_run) begin
                        r_state <= S_RUN;
                        r_idx   <= '0;
                        r_en    <= c_en_first;
                        r_wd    <= '0;
                    end
                end

                S_RUN: begin
                    if (i_flush) begin
                        // Flush beats both stall and completion: the
                        // abandoned instruction is never counted.
                        r_idx <= '0;
                        r_en  <= c_en_first;
                        r_wd  <= '0;
                    end else if (w_hold) begin
                        r_wd <= r_wd + TO_W'(1);
                    end else begin
                        r_wd <= '0;
                        if (w_busy) begin
                            r_timeout <= 1'b1;
                        end
                        if (w_last) begin
                            r_done    <= 1'b1;
                            r_retired <= r_retired + CNT_W'(1);
                            r_idx     <= '0;
                            if (i_halt || !i_run) begin
                                r_state <= S_HALTED;
                                r_en    <= '0;
                            end else begin
                                r_en <= c_en_first;
                            end
                        end else begin
                            r_idx <= r_idx + IDX_W'(1);
                            r_en  <= {r_en[NUM_STAGES-2:0], 1'b0};
                        end
                    end
                end

                S_HALTED: begin
                    if (i_run && !i_halt) begin
                        r_state <= S_RUN;
                        r_idx   <= '0;
                        r_en    <= c_en_first;
                        r_wd    <= '0;
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                    r_idx   <= '0;
                    r_en    <= '0;
                    r_wd    <= '0;
                end
            endcase
        end
    end

    assign o_stage_en   = r_en;
    assign o_stage_idx  = r_idx;
    assign o_instr_done = r_done;
    assign o_retired    = r_retired;
    assign o_timeout    = r_timeout;
    assign o_state      = r_state;

endmodule
`default_nettype wire

// File: tb/tb_stage_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_stage_sequencer
// Description : Self-checking bench for stage_sequencer (5 stages, 4-bit
//               retired counter, watchdog limit 3). A cycle model pushes the
//               expected outputs to a queue before each clock edge; they are
//               popped and compared just after the edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_stage_sequencer;

    localparam int NS = 5;
    localparam int CW = 4;
    localparam int TO = 3;
    localparam int TW = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          run;
    logic          halt;
    logic          flush;
    logic [NS-1:0] busy;
    logic [NS-1:0] stage_en;
    logic [2:0]    stage_idx;
    logic          instr_done;
    logic [CW-1:0] retired;
    logic          timeout;
    logic [1:0]    state;

    stage_sequencer #(
        .NUM_STAGES(NS),
        .CNT_W     (CW),
        .TIMEOUT   (TO),
        .TO_W      (TW)
    ) dut (
        .i_clk       (clk),
        .i_reset     (reset),
        .i_run       (run),
        .i_halt      (halt),
        .i_flush     (flush),
        .i_stage_busy(busy),
        .o_stage_en  (stage_en),
        .o_stage_idx (stage_idx),
        .o_instr_done(instr_done),
        .o_retired   (retired),
        .o_timeout   (timeout),
        .o_state     (state)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [NS-1:0] en;
        logic [2:0]    idx;
        logic          done;
        logic [CW-1:0] ret;
        logic          to;
        logic [1:0]    st;
    } exp_t;

    exp_t sb[$];

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    int            m_state;
    int            m_idx;
    int            m_wd;
    logic          m_done;
    logic          m_to;
    logic [CW-1:0] m_ret;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_state = 0;
        m_idx   = 0;
        m_wd    = 0;
        m_done  = 1'b0;
        m_to    = 1'b0;
        m_ret   = '0;
        sb.delete();
    endtask

    // Advance the model by one clock using the inputs the DUT will sample.
    task automatic model_step();
        exp_t          e;
        logic [NS-1:0] one;
        m_done = 1'b0;
        case (m_state)
            0: if (run) begin m_state = 1; m_idx = 0; m_wd = 0; end
            1: begin
                if (flush) begin
                    m_idx = 0;
                    m_wd  = 0;
                end else if (busy[m_idx] && !(TO > 0 && m_wd >= TO)) begin
                    m_wd++;
                end else begin
                    if (busy[m_idx]) m_to = 1'b1;
                    m_wd = 0;
                    if (m_idx == NS - 1) begin
                        m_done = 1'b1;
                        m_ret  = m_ret + 1'b1;
                        m_idx  = 0;
                        if (halt || !run) m_state = 2;
                    end else begin
                        m_idx++;
                    end
                end
            end
            default: if (run && !halt) begin m_state = 1; m_idx = 0; m_wd = 0; end
        endcase
        one   = 1;
        e.en  = (m_state == 1) ? (one << m_idx) : '0;
        e.idx = 3'(m_idx);
        e.done = m_done;
        e.ret = m_ret;
        e.to  = m_to;
        e.st  = 2'(m_state);
        sb.push_back(e);
    endtask

    task automatic cycle();
        exp_t e;
        model_step();
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            check("scoreboard_empty", 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            check("stage_en", 32'(stage_en), 32'(e.en));
            check("stage_idx", 32'(stage_idx), 32'(e.idx));
            check("instr_done", 32'(instr_done), 32'(e.done));
            check("retired", 32'(retired), 32'(e.ret));
            check("timeout", 32'(timeout), 32'(e.to));
            check("state", 32'(state), 32'(e.st));
        end
        check("onehot", 32'($countones(stage_en) <= 1), 32'd1);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_en"}, 32'(stage_en), 32'd0);
        check({tag, "_idx"}, 32'(stage_idx), 32'd0);
        check({tag, "_done"}, 32'(instr_done), 32'd0);
        check({tag, "_ret"}, 32'(retired), 32'd0);
        check({tag, "_to"}, 32'(timeout), 32'd0);
        check({tag, "_state"}, 32'(state), 32'd0);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        check_reset_values("reset");
        model_reset();
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Bounded wait until the active stage equals target.
    task automatic advance_to(input int target);
        int n;
        n = 0;
        while (!(m_state == 1 && m_idx == target) && n < 40) begin
            cycle();
            n++;
        end
        if (!(m_state == 1 && m_idx == target)) check("advance_bound", 32'd0, 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [NS-1:0] one;
        logic [CW-1:0] r0;
        int            cnt;
        logic          seen;

        reset = 1'b1;
        run   = 1'b0;
        halt  = 1'b0;
        flush = 1'b0;
        busy  = '0;
        model_reset();
        #12;
        check_reset_values("por");
        apply_reset();

        // Free-running instruction: stages 0..4 then wrap with done pulse.
        run = 1'b1;
        one = 1;
        for (int k = 0; k < NS; k++) begin
            cycle();
            check("t1_en", 32'(stage_en), 32'(one << k));
        end
        cycle();
        check("t1_done", 32'(instr_done), 32'd1);
        check("t1_ret", 32'(retired), 32'd1);
        check("t1_en_wrap", 32'(stage_en), 32'd1);

        // Stall on stage 3 for three busy cycles (below the watchdog limit).
        advance_to(3);
        cnt = 1;
        busy = 5'b01000;
        repeat (3) begin
            cycle();
            cnt += int'(stage_en[3]);
        end
        busy = '0;
        cycle();
        check("t2_stage3_cycles", 32'(cnt), 32'd4);
        check("t2_en4", 32'(stage_en), 32'b10000);
        r0 = retired;
        cycle();
        check("t2_done", 32'(instr_done), 32'd1);
        check("t2_ret", 32'(retired), 32'(r0 + 4'd1));
        check("t2_to", 32'(timeout), 32'd0);

        // Flush mid-instruction.
        advance_to(2);
        r0 = retired;
        flush = 1'b1;
        cycle();
        flush = 1'b0;
        check("t3_en", 32'(stage_en), 32'd1);
        check("t3_done", 32'(instr_done), 32'd0);
        check("t3_ret", 32'(retired), 32'(r0));

        // Halt requested at stage 1 completes the instruction first.
        advance_to(1);
        halt = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 10 && m_state != 2; i++) begin
            cycle();
            seen |= instr_done;
        end
        check("t4_done_seen", 32'(seen), 32'd1);
        check("t4_state", 32'(state), 32'd2);
        check("t4_en", 32'(stage_en), 32'd0);
        repeat (2) cycle();
        halt = 1'b0;
        cycle();
        check("t4_resume_en", 32'(stage_en), 32'd1);

        // Flush coinciding with last-stage completion is not counted.
        advance_to(4);
        r0 = retired;
        flush = 1'b1;
        cycle();
        flush = 1'b0;
        check("t5_done", 32'(instr_done), 32'd0);
        check("t5_ret", 32'(retired), 32'(r0));
        check("t5_en", 32'(stage_en), 32'd1);

        // Flush while HALTED is ignored.
        halt = 1'b1;
        for (int i = 0; i < 10 && m_state != 2; i++) cycle();
        flush = 1'b1;
        cycle();
        flush = 1'b0;
        check("t5_halted_flush", 32'(state), 32'd2);
        halt = 1'b0;
        cycle();

        // Watchdog: stage 4 stuck busy is forced on after three held cycles.
        advance_to(4);
        r0 = retired;
        busy = 5'b10000;
        repeat (3) cycle();
        check("t6_held", 32'(stage_en), 32'b10000);
        check("t6_to_early", 32'(timeout), 32'd0);
        cycle();
        check("t6_to", 32'(timeout), 32'd1);
        check("t6_done", 32'(instr_done), 32'd1);
        check("t6_ret", 32'(retired), 32'(r0 + 4'd1));
        busy = '0;
        repeat (5) cycle();
        check("t6_sticky", 32'(timeout), 32'd1);

        // Mixed random traffic against the model.
        for (int i = 0; i < 300; i++) begin
            run   = ($urandom_range(7) != 0);
            halt  = ($urandom_range(15) == 0);
            flush = ($urandom_range(11) == 0);
            busy  = NS'($urandom & $urandom);
            cycle();
        end
        run = 1'b0; halt = 1'b0; flush = 1'b0; busy = '0;

        // Counter wrap: sixteen back-to-back instructions.
        apply_reset();
        run = 1'b1;
        for (int k = 1; k <= 81; k++) begin
            cycle();
            if (k == 76) check("t8_ret15", 32'(retired), 32'd15);
            if (k == 81) begin
                check("t8_wrap", 32'(retired), 32'd0);
                check("t8_done", 32'(instr_done), 32'd1);
            end
        end

        // Asynchronous reset in the middle of stage 2.
        advance_to(2);
        #2;
        reset = 1'b1;
        #1;
        check_reset_values("async");
        model_reset();
        @(negedge clk);
        reset = 1'b0;
        run = 1'b0;
        cycle();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/stage_sequencer.md
Name: stage_sequencer

Overview:
- Parametrised successor to the fixed three-phase clock generator.
- Runs from a single core clock. Produces one-hot per-stage clock enables for an N-stage multicycle core (default IF/ID/EX/MEM/WB) instead of derived clocks.
- Adds per-stage busy stalls, flush-to-fetch, halt-at-boundary, a stall watchdog and a retired-instruction counter.
- Sits at core top level. Drives the enables of the IF, ID, EX, MEM and WB stage blocks.

Parameters:
- NUM_STAGES, 5, number of stages; legal range 2..16.
- CNT_W, 32, width of retired-instruction counter.
- TIMEOUT, 255, max consecutive busy cycles tolerated on one stage; 0 disables the watchdog.
- TO_W, 8, width of watchdog counter; must satisfy TIMEOUT < 2**TO_W.

Ports:
- i_clk  in  1  core clock, rising edge.
- i_reset  in  1  asynchronous reset, active-high.
- i_run  in  1  level; enables sequencing out of IDLE/HALTED.
- i_halt  in  1  level; request stop at next instruction boundary.
- i_flush  in  1  pulse; abandon current instruction and restart at stage 0 (taken branch/jump).
- i_stage_busy  in  NUM_STAGES  per-stage busy; bit k holds the sequencer in stage k.
- o_stage_en  out  NUM_STAGES  one-hot enable of the active stage; all-zero when not RUN.
- o_stage_idx  out  $clog2(NUM_STAGES)  index of the active stage.
- o_instr_done  out  1  one-cycle pulse when the last stage completes.
- o_retired  out  CNT_W  count of completed instructions.
- o_timeout  out  1  sticky; watchdog fired.
- o_state  out  2  IDLE=0, RUN=1, HALTED=2.

Behaviour:
- Reset (async assert, sync release): state=IDLE, stage_idx=0, stage_en=0, instr_done=0, retired=0, timeout=0, watchdog cnt=0.
- States:
  - IDLE: if i_run, go to RUN with stage_idx=0. Enable appears on the first cycle after i_run is sampled (1-cycle latency).
  - RUN: o_stage_en = 1<<stage_idx, registered output.
    - Advance each cycle unless i_stage_busy[stage_idx]=1.
    - While busy, hold stage_idx and keep enable asserted.
  - Completion of stage NUM_STAGES-1 (enable high and not busy):
    - o_instr_done=1 on the next cycle; o_retired += 1, wrapping modulo 2**CNT_W.
    - If i_halt=1 or i_run=0, next state=HALTED. Otherwise stage_idx wraps to 0.
  - HALTED: stage_en=0, stage_idx=0. Return to RUN when i_run=1 and i_halt=0; stage 0 is enabled the following cycle.
- i_halt mid-instruction has no effect until the instruction boundary; it never truncates an instruction.
- i_flush in RUN: next stage_idx=0; no instr_done; retired unchanged; watchdog cleared.
  - Flush has priority over busy and over advance.
  - Flush coinciding with last-stage completion: flush wins and the instruction is not counted.
  - Flush in IDLE or HALTED is ignored.
- Watchdog (TIMEOUT>0):
  - Counts consecutive cycles with the current stage busy; clears on advance or flush.
  - When the count reaches TIMEOUT, force the stage to advance as if not busy and set o_timeout.
  - o_timeout clears only on reset.
- Stage 0 completion and i_run=0 mid-instruction: the instruction still runs to completion.
- Reset asserted mid-instruction: all outputs go to reset values immediately (asynchronous); no instr_done pulse.
- o_stage_en is always one-hot or zero; never multi-hot.

Test Plan:
- Reset release, i_run=1, busy=0, NUM_STAGES=5 -> enables 00001,00010,00100,01000,10000 on cycles 1..5; instr_done on cycle 6; retired=1; stage 0 enabled again on cycle 6.
- busy[3] held 4 cycles -> stage 3 enable stays high 5 cycles total; retired increments once; timeout=0.
- i_flush while stage_idx=2 -> next cycle stage_en=00001; retired unchanged; no instr_done.
- i_halt asserted at stage 1 -> instruction finishes; instr_done pulses; state=HALTED; stage_en=0. Deassert halt -> stage 0 enabled next cycle.
- TIMEOUT=3, busy[4] stuck high -> stage 4 forced to advance after 3 busy cycles; o_timeout=1, sticky until reset; retired increments.
- CNT_W=4, run 16 instructions -> o_retired wraps 15 to 0. Assert i_reset mid-stage-2 -> all outputs zero and state=IDLE, asynchronously.
